// File: rtl/sm_mem_arbiter.sv
// sm_mem_arbiter
// Shares one variable-latency memory port between the instruction-fetch
// requester (F) and the load/store requester (D). Round-robin arbitration
// holds the grant until the memory acks. A watchdog aborts any grant that
// waits too long for m_ack.
//
// Handshake (all ports):
//   A requester raises *_req and keeps it, with its address/control/data
//   stable, until it sees *_ack or *_err for one cycle. Exactly one of
//   those two pulses ends each request. The memory sees m_req high for the
//   whole grant, with m_we/m_addr/m_wdata stable, and ends it with a
//   one-cycle m_ack. m_rdata is valid in that cycle. m_ack is ignored while
//   m_req is low. The one-hot grant output mirrors the FSM state
//   (00 idle, 01 fetch, 10 data) so checkers can follow the controller.
module sm_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  // fetch requester
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic          f_err,
  output logic [DW-1:0] f_rdata,
  // load/store requester
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic          d_err,
  output logic [DW-1:0] d_rdata,
  // memory side
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  // current owner, one-hot
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G_F  = 2'b01,
    G_D  = 2'b10
  } state_t;

  // A TIMEOUT of 0 turns the watchdog off. T_LAST is the timer value seen in
  // the final grant cycle that is allowed before the abort.
  localparam bit         WD_EN  = (TIMEOUT != 0);
  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     nextState;
  state_t     pick;
  logic       lastD;      // 1 when D was the most recent owner
  logic [7:0] timer;      // grant cycles spent without m_ack

  logic ownF;
  logic ownD;
  logic busy;
  logic timeoutHit;
  logic done;
  logic arbNow;
  logic candF;
  logic candD;

  // Owner decode and end-of-grant detection (ack wins over abort)
  always_comb begin
    ownF       = (state == G_F);
    ownD       = (state == G_D);
    busy       = ownF | ownD;
    timeoutHit = WD_EN && busy && !m_ack && (timer == T_LAST);
    done       = busy && (m_ack || timeoutHit);
    arbNow     = !busy || done;
  end

  // Round-robin pick. The owner that finishes this cycle cannot win again
  // right away, so the other requester goes next without an idle bubble.
  always_comb begin
    candF = f_req && !(ownF && done);
    candD = d_req && !(ownD && done);
    pick  = IDLE;
    if (candF && candD) begin
      pick = lastD ? G_F : G_D;
    end else if (candF) begin
      pick = G_F;
    end else if (candD) begin
      pick = G_D;
    end
    nextState = arbNow ? pick : state;
  end

  // Controller FSM with registered grant/m_req, round-robin history and watchdog timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 2'b00;
      m_req <= 1'b0;
      lastD <= 1'b1;
      timer <= 8'd0;
    end else begin
      state <= nextState;
      grant <= nextState;
      m_req <= (nextState != IDLE);
      if (done) begin
        lastD <= ownD;
      end
      if (arbNow) begin
        timer <= 8'd0;
      end else if (timer != 8'hFF) begin
        timer <= timer + 8'd1;
      end
    end
  end

  // Completion pulses and read-data return, valid only for the current owner
  always_comb begin
    f_ack   = ownF & m_ack;
    d_ack   = ownD & m_ack;
    f_err   = ownF & timeoutHit;
    d_err   = ownD & timeoutHit;
    f_rdata = m_rdata;
    d_rdata = m_rdata;
  end

  // Memory command mux. Fetches are always reads. Idle drives zeros.
  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (ownF) begin
      m_addr = f_addr;
    end else if (ownD) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end
  end

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// tb_sm_mem_arbiter
// Random fetch/data traffic runs against a reactive memory. The memory
// pulses m_ack after 0..5 cycles, so some accesses hit the watchdog
// (TIMEOUT=4). It also sends stray acks while idle. A reset is forced in the
// 2nd cycle of some D grants. A transaction-level reference model predicts
// the per-cycle memory command and the completion events. A monitor compares
// these against the DUT.
module tb_sm_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int CW = 2 + 1 + 1 + AW + DW;   // {grant, m_req, m_we, m_addr, m_wdata}
  localparam int EW = 4 + DW;                // {f_ack, d_ack, f_err, d_err, rdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_ack, f_err;
  logic [DW-1:0] f_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack, d_err;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic [1:0]    grant;

  sm_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .grant(grant)
  );

  // ---------------- scoreboard state ----------------
  logic [CW-1:0] cyc_q[$];
  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  bit drv_en = 1'b1;
  int n_resets = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_f();
    bit pending = 1'b0;
    bit first = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!pending) begin
        if (drv_en && (first || $urandom_range(0, 2) != 0)) begin
          f_req   = 1'b1;
          f_addr  = $urandom;
          pending = 1'b1;
          first   = 1'b0;
        end else begin
          f_req  = 1'b0;
          f_addr = $urandom;
        end
      end
      @(negedge clk);
      if (f_ack || f_err) pending = 1'b0;
    end
  endtask

  task automatic drive_d();
    bit pending = 1'b0;
    bit first = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!pending) begin
        if (drv_en && (first || $urandom_range(0, 2) != 0)) begin
          d_req   = 1'b1;
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = $urandom;
          d_wdata = $urandom;
          pending = 1'b1;
          first   = 1'b0;
        end else begin
          d_req   = 1'b0;
          d_we    = 1'($urandom_range(0, 1));
          d_addr  = $urandom;
          d_wdata = $urandom;
        end
      end
      @(negedge clk);
      if (d_ack || d_err) pending = 1'b0;
    end
  endtask

  initial begin : f_driver
    @(negedge rst);
    drive_f();
  end

  initial begin : d_driver
    @(negedge rst);
    drive_d();
  end

  // Memory: acks each new m_req after 0..5 cycles. 4 or 5 trips the
  // watchdog, and 3 lands exactly on the abort cycle. Stray acks while idle.
  initial begin : mem_responder
    bit busy = 1'b0;
    int wait_n = 0;
    forever begin
      @(posedge clk); #1;
      m_rdata = $urandom;
      if (rst) begin
        busy  = 1'b0;
        m_ack = 1'b0;
      end else begin
        if (m_req && !busy) begin
          busy   = 1'b1;
          wait_n = $urandom_range(0, 5);
        end
        if (busy) begin
          m_ack = (wait_n == 0);
          if (wait_n > 0) wait_n--;
        end else begin
          m_ack = ($urandom_range(0, 5) == 0);
        end
      end
      @(negedge clk);
      if (f_ack || d_ack || f_err || d_err) busy = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // Owner is 0 (none), 1 (F) or 2 (D). age counts the cycles already spent
  // in the current grant. Each cycle the model pushes the expected memory
  // command. It also pushes an event when a grant ends by ack or abort.
  initial begin : ref_model
    int own = 0;
    int age = 0;
    bit last_d = 1'b1;
    bit ack, abort, wf, wd;
    logic [1:0] eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    forever begin
      @(negedge clk);
      if (rst) begin
        own = 0; age = 0; last_d = 1'b1;
        cyc_q.push_back('0);
      end else begin
        eg  = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
        ea  = (own == 1) ? f_addr : (own == 2) ? d_addr : '0;
        ewd = (own == 2) ? d_wdata : '0;
        cyc_q.push_back({eg, 1'(own != 0), 1'(own == 2 && d_we), ea, ewd});
        ack   = (own != 0) && m_ack;
        abort = (own != 0) && !m_ack && (age == TO - 1);
        if (ack || abort) begin
          exp_q.push_back({1'(own == 1 && ack), 1'(own == 2 && ack),
                           1'(own == 1 && abort), 1'(own == 2 && abort),
                           ack ? m_rdata : {DW{1'b0}}});
          last_d = (own == 2);
        end
        if (own == 0 || ack || abort) begin
          wf = f_req && own != 1;
          wd = d_req && own != 2;
          if (wf && wd)  own = last_d ? 1 : 2;
          else if (wf)   own = 1;
          else if (wd)   own = 2;
          else           own = 0;
          age = 0;
        end else begin
          age++;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [CW-1:0] ec;
    logic [EW-1:0] ee, ae;
    forever begin
      @(negedge clk); #1;
      if (cyc_q.size() != 0) begin
        ec = cyc_q.pop_front();
        check("cycle_cmd", 80'({grant, m_req, m_we, m_addr, m_wdata}), 80'(ec));
      end
      if (f_ack || d_ack || f_err || d_err) begin
        ae = {f_ack, d_ack, f_err, d_err,
              f_ack ? f_rdata : d_ack ? d_rdata : {DW{1'b0}}};
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 80'(ae), 80'(0));
        end else begin
          ee = exp_q.pop_front();
          check("completion", 80'(ae), 80'(ee));
        end
      end
    end
  end

  // ---------------- main sequence / final report ----------------
  initial begin : main_seq
    int d_run = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if (rst) begin
        rst   = 1'b0;
        d_run = 0;
      end else begin
        if (grant == 2'b10) d_run++;
        else                d_run = 0;
        if (d_run == 2 && f_req && d_req && n_resets < 3 && c > 50) begin
          rst = 1'b1;
          n_resets++;
          d_run = 0;
        end
      end
    end
    drv_en = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk); #3;
    check("exp_q_drained", 80'(exp_q.size()), 80'(0));
    check("final_idle", 80'({grant, m_req}), 80'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
